servo_sequencer: RTL and testbench

- Upstream command stage for the servo PWM generator.
- Turns a start button / stop request into a timed open/close sequence.
- Drives the PWM stage's `control_input` (angle select) and `main_program` (enable).
- Runs a settle period, then a programmable number of open/close cycles with ms-accurate dwell; reports busy/done/cycle count.

---
 rtl/servo_sequencer.sv | 171 +++++++++++++++++
 tb/tb_servo_sequencer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/servo_sequencer.sv
// servo_sequencer: start/stop command stage ahead of the servo PWM generator.
// Runs SETTLE, then CYCLES open/close cycles with ms-granular dwell, and
// drives the PWM angle select (control_input) and enable (main_program).
// Optional start-button debounce filter: define SERVO_SEQ_DEBOUNCE_EN.
module servo_sequencer #(
  parameter int MS_DIV      = 50000,
  parameter int SETTLE_MS   = 100,
  parameter int OPEN_MS     = 1000,
  parameter int CLOSE_MS    = 1000,
  parameter int CYCLES      = 3,
  parameter int DEBOUNCE_MS = 20
) (
  input  logic       mclk,
  input  logic       reset,
  input  logic       start_btn,
  input  logic       stop,
  output logic       control_input,
  output logic       main_program,
  output logic       busy,
  output logic       done,
  output logic [7:0] cycle_cnt
);

  localparam int PW   = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
  localparam int DMX0 = (SETTLE_MS > OPEN_MS) ? SETTLE_MS : OPEN_MS;
  localparam int DMAX = (DMX0 > CLOSE_MS) ? DMX0 : CLOSE_MS;
  localparam int DW   = (DMAX > 1) ? $clog2(DMAX) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_OPEN, S_CLOSE} state_t;

  state_t          state, state_n;
  logic            sync1, sync2, edge_src, edge_d, start_pulse;
  logic [PW-1:0]   presc;
  logic [DW-1:0]   dwell;
  logic            tick, dwell_last, expire, fin, fin_q, last_cycle;
  logic [7:0]      cnt_inc;

  // Two-flop synchronizer for the button plus edge-detect history
  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      edge_d <= 1'b0;
    end else begin
      sync1  <= start_btn;
      sync2  <= sync1;
      edge_d <= edge_src;
    end
  end

`ifdef SERVO_SEQ_DEBOUNCE_EN
  localparam int DBW = (DEBOUNCE_MS > 1) ? $clog2(DEBOUNCE_MS) : 1;
  logic [PW-1:0]  db_presc;
  logic [DBW-1:0] db_cnt;
  logic           db_out, db_tick;

  assign db_tick  = (db_presc == PW'(MS_DIV - 1));
  assign edge_src = db_out;

  // Filter follows sync2 only after it has disagreed for DEBOUNCE_MS whole ticks
  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) begin
      db_presc <= '0;
      db_cnt   <= '0;
      db_out   <= 1'b0;
    end else begin
      db_presc <= db_tick ? '0 : db_presc + PW'(1);
      if (sync2 == db_out) begin
        db_cnt <= '0;
      end else if (db_tick) begin
        if (db_cnt == DBW'(DEBOUNCE_MS - 1)) begin
          db_out <= sync2;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + DBW'(1);
        end
      end
    end
  end
`else
  logic unused_debounce;
  assign unused_debounce = (DEBOUNCE_MS != 0);
  assign edge_src        = sync2;
`endif

  assign start_pulse = edge_src & ~edge_d;
  assign tick        = (presc == PW'(MS_DIV - 1));
  assign expire      = tick & dwell_last;
  assign cnt_inc     = (cycle_cnt == 8'hFF) ? cycle_cnt : cycle_cnt + 8'd1;
  assign last_cycle  = (CYCLES != 0) && (cnt_inc == 8'(CYCLES));

  // Pick the dwell length of the current state
  always_comb begin
    dwell_last = 1'b0;
    case (state)
      S_SETTLE: dwell_last = (dwell == DW'(SETTLE_MS - 1));
      S_OPEN:   dwell_last = (dwell == DW'(OPEN_MS - 1));
      S_CLOSE:  dwell_last = (dwell == DW'(CLOSE_MS - 1));
      default:  dwell_last = 1'b0;
    endcase
  end

  // Next state; stop beats both start and dwell expiry
  always_comb begin
    state_n = state;
    fin     = 1'b0;
    case (state)
      S_IDLE:   if (start_pulse && !stop) state_n = S_SETTLE;
      S_SETTLE: if (stop) state_n = S_IDLE; else if (expire) state_n = S_OPEN;
      S_OPEN:   if (stop) state_n = S_IDLE; else if (expire) state_n = S_CLOSE;
      S_CLOSE: begin
        if (stop) begin
          state_n = S_IDLE;
        end else if (expire) begin
          if (last_cycle) begin
            state_n = S_IDLE;
            fin     = 1'b1;
          end else begin
            state_n = S_OPEN;
          end
        end
      end
      default:  state_n = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_n;
  end

  // ms prescaler and dwell counter restart on every state entry
  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) begin
      presc <= '0;
      dwell <= '0;
    end else if (state_n != state || state == S_IDLE) begin
      presc <= '0;
      dwell <= '0;
    end else begin
      presc <= tick ? '0 : presc + PW'(1);
      if (tick) dwell <= dwell + DW'(1);
    end
  end

  // Completed-cycle counter: cleared on accepted start, bumped at CLOSE end
  always_ff @(posedge mclk or negedge reset) begin
    if (!reset)                                      cycle_cnt <= 8'd0;
    else if (state == S_IDLE && state_n == S_SETTLE) cycle_cnt <= 8'd0;
    else if (state == S_CLOSE && expire && !stop)    cycle_cnt <= cnt_inc;
  end

  // Registered Moore outputs; done lands on the cycle busy drops
  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) begin
      main_program  <= 1'b0;
      control_input <= 1'b0;
      busy          <= 1'b0;
      fin_q         <= 1'b0;
      done          <= 1'b0;
    end else begin
      main_program  <= (state != S_IDLE);
      control_input <= (state == S_OPEN);
      busy          <= (state != S_IDLE);
      fin_q         <= fin;
      done          <= fin_q;
    end
  end

endmodule

// File: tb/tb_servo_sequencer.sv
// Testbench for servo_sequencer (default build, no debounce).
// Expected waveforms come from a timeline model: given the edge at which a
// run starts and an optional stop time, the state at any cycle is derived
// from the SETTLE/OPEN/CLOSE durations with plain division and modulo.
module tb_servo_sequencer;

  localparam int MS_DIV    = 10;
  localparam int SETTLE_MS = 2;
  localparam int OPEN_MS   = 3;
  localparam int CLOSE_MS  = 3;
  localparam int CYCLES    = 2;
  localparam int SD        = SETTLE_MS * MS_DIV;
  localparam int OD        = OPEN_MS * MS_DIV;
  localparam int CD        = CLOSE_MS * MS_DIV;
  localparam int PD        = OD + CD;
  localparam int NEVER     = 1 << 30;

  logic       mclk = 1'b0, reset = 1'b0;
  logic       start_btn = 1'b0, stop = 1'b0, start2 = 1'b0, stop2 = 1'b0;
  logic       control_input, main_program, busy, done;
  logic [7:0] cycle_cnt;
  logic       ci2, mp2, busy2, done2;
  logic [7:0] cnt2;

  int checks = 0;
  int errors = 0;
  int last_cnt = 0;

  servo_sequencer #(.MS_DIV(MS_DIV), .SETTLE_MS(SETTLE_MS), .OPEN_MS(OPEN_MS),
                    .CLOSE_MS(CLOSE_MS), .CYCLES(CYCLES), .DEBOUNCE_MS(2)) dut (
    .mclk(mclk), .reset(reset), .start_btn(start_btn), .stop(stop),
    .control_input(control_input), .main_program(main_program),
    .busy(busy), .done(done), .cycle_cnt(cycle_cnt));

  servo_sequencer #(.MS_DIV(MS_DIV), .SETTLE_MS(SETTLE_MS), .OPEN_MS(OPEN_MS),
                    .CLOSE_MS(CLOSE_MS), .CYCLES(0), .DEBOUNCE_MS(2)) dut_c (
    .mclk(mclk), .reset(reset), .start_btn(start2), .stop(stop2),
    .control_input(ci2), .main_program(mp2),
    .busy(busy2), .done(done2), .cycle_cnt(cnt2));

  always #5 mclk = ~mclk;

  // Phase at t cycles after the run begins: 0 idle, 1 settle, 2 open, 3 close
  function automatic int phase_at(int t, int ts, int cyc);
    int u;
    if (t < 0 || t >= ts) return 0;
    if (t < SD) return 1;
    u = t - SD;
    if (cyc != 0 && (u / PD) >= cyc) return 0;
    return ((u % PD) < OD) ? 2 : 3;
  endfunction

  // Completed cycles by time t; stop freezes the count at the cycle before it
  function automatic int count_at(int t, int ts, int cyc);
    int tt, c;
    tt = (t >= ts) ? ts - 1 : t;
    if (tt < SD) return 0;
    c = (tt - SD) / PD;
    if (cyc != 0 && c > cyc) c = cyc;
    if (c > 255) c = 255;
    return c;
  endfunction

  // Expected {main_program, control_input, busy, done, cycle_cnt} after edge n,
  // where start_btn first rose ahead of edge 1 and the FSM sees it at edge 3.
  function automatic logic [11:0] exp_vec(int n, int ts, int cyc, int prev);
    int t, ph, tc, c;
    logic d;
    t  = n - 3;
    ph = phase_at(t - 1, ts, cyc);
    tc = SD + cyc * PD;
    d  = (cyc != 0) && (t == tc + 1) && (ts > tc);
    c  = (t < 0 || ts <= 0) ? prev : count_at(t, ts, cyc);
    return {ph != 0, ph == 2, ph != 0, d, 8'(c)};
  endfunction

  task automatic test_reset();
    logic [11:0] got, e;
    reset = 1'b0; start_btn = 1'b0; stop = 1'b0;
    repeat (3) @(negedge mclk);
    got = {main_program, control_input, busy, done, cycle_cnt};
    checks++;
    if (got !== 12'h000) begin
      errors++; $display("FAIL reset_hold got=%h exp=000", got);
    end
    reset = 1'b1;
    repeat (3) @(negedge mclk);
    got = {main_program, control_input, busy, done, cycle_cnt};
    checks++;
    if (got !== 12'h000) begin
      errors++; $display("FAIL reset_release got=%h exp=000", got);
    end
    // start a run and pull reset in the middle of the first OPEN
    start_btn = 1'b1;
    @(negedge mclk);
    start_btn = 1'b0;
    repeat (33) @(negedge mclk);
    got = {main_program, control_input, busy, done, cycle_cnt};
    e   = exp_vec(34, NEVER, CYCLES, 0);
    checks++;
    if (got !== e) begin
      errors++; $display("FAIL pre_reset_open got=%h exp=%h", got, e);
    end
    #2 reset = 1'b0;
    #1;
    got = {main_program, control_input, busy, done, cycle_cnt};
    checks++;
    if (got !== 12'h000) begin
      errors++; $display("FAIL reset_async got=%h exp=000", got);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge mclk);
      got = {main_program, control_input, busy, done, cycle_cnt};
      checks++;
      if (got !== 12'h000) begin
        errors++; $display("FAIL reset_mid_run cyc=%0d got=%h exp=000", i, got);
      end
    end
    reset = 1'b1;
    @(negedge mclk);
    last_cnt = 0;
  endtask

  task automatic test_plain_run();
    logic [11:0] got, e;
    int hold;
    hold = $urandom_range(1, 8);
    start_btn = 1'b1;
    for (int n = 1; n <= 170; n++) begin
      @(negedge mclk);
      got = {main_program, control_input, busy, done, cycle_cnt};
      e   = exp_vec(n, NEVER, CYCLES, last_cnt);
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL plain_run n=%0d hold=%0d mp/ci/busy/done/cnt got=%b/%b/%b/%b/%0d exp=%b/%b/%b/%b/%0d",
                 n, hold, got[11], got[10], got[9], got[8], got[7:0], e[11], e[10], e[9], e[8], e[7:0]);
      end
      start_btn = (n + 1 <= hold);
    end
    start_btn = 1'b0;
    last_cnt  = int'(exp_vec(170, NEVER, CYCLES, last_cnt) & 12'h0FF);
  endtask

  task automatic test_stop();
    int ts_list[4];
    logic [11:0] got, e;
    ts_list[0] = 0;                  // stop coincides with start_pulse in IDLE
    ts_list[1] = SD + 25;            // mid first OPEN
    ts_list[2] = SD + PD;            // same edge as first CLOSE expiry
    ts_list[3] = $urandom_range(1, SD + 2 * PD - 1);
    for (int k = 0; k < 4; k++) begin
      start_btn = 1'b1;
      stop      = (ts_list[k] == -2);
      for (int n = 1; n <= 170; n++) begin
        @(negedge mclk);
        got = {main_program, control_input, busy, done, cycle_cnt};
        e   = exp_vec(n, ts_list[k], CYCLES, last_cnt);
        checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL stop ts=%0d n=%0d mp/ci/busy/done/cnt got=%b/%b/%b/%b/%0d exp=%b/%b/%b/%b/%0d",
                   ts_list[k], n, got[11], got[10], got[9], got[8], got[7:0],
                   e[11], e[10], e[9], e[8], e[7:0]);
        end
        start_btn = (n + 1 <= 2);
        stop      = (n + 1 == 3 + ts_list[k]);
      end
      stop     = 1'b0;
      last_cnt = int'(exp_vec(170, ts_list[k], CYCLES, last_cnt) & 12'h0FF);
    end
  endtask

  task automatic test_ignore_start();
    logic [11:0] got, e;
    int hold, rp, len;
    hold = $urandom_range(1, 8);
    rp   = 3 + SD + OD + $urandom_range(0, 1) * PD + $urandom_range(0, CD - 4);
    len  = $urandom_range(1, 4);
    start_btn = 1'b1;
    for (int n = 1; n <= 170; n++) begin
      @(negedge mclk);
      got = {main_program, control_input, busy, done, cycle_cnt};
      e   = exp_vec(n, NEVER, CYCLES, last_cnt);
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL ignore_start rp=%0d n=%0d mp/ci/busy/done/cnt got=%b/%b/%b/%b/%0d exp=%b/%b/%b/%b/%0d",
                 rp, n, got[11], got[10], got[9], got[8], got[7:0], e[11], e[10], e[9], e[8], e[7:0]);
      end
      start_btn = (n + 1 <= hold) || (n + 1 >= rp && n + 1 < rp + len);
    end
    start_btn = 1'b0;
    last_cnt  = int'(exp_vec(170, NEVER, CYCLES, last_cnt) & 12'h0FF);
  endtask

  task automatic test_continuous();
    logic [11:0] got, e;
    int ts, nend;
    ts   = SD + 300 * PD + 2;
    nend = 3 + ts + 4;
    start2 = 1'b1;
    for (int n = 1; n <= nend; n++) begin
      @(negedge mclk);
      got = {mp2, ci2, busy2, done2, cnt2};
      e   = exp_vec(n, ts, 0, 0);
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL continuous n=%0d mp/ci/busy/done/cnt got=%b/%b/%b/%b/%0d exp=%b/%b/%b/%b/%0d",
                 n, got[11], got[10], got[9], got[8], got[7:0], e[11], e[10], e[9], e[8], e[7:0]);
      end
      start2 = (n + 1 <= 3);
      stop2  = (n + 1 == 3 + ts);
    end
    checks++;
    if (cnt2 !== 8'd255 || mp2 !== 1'b0) begin
      errors++; $display("FAIL saturate_stop cnt=%0d mp=%b exp cnt=255 mp=0", cnt2, mp2);
    end
  endtask

  initial begin
    test_reset();
    test_plain_run();
    test_stop();
    test_ignore_start();
    test_plain_run();
    test_continuous();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
